// File: rtl/synth_pkg.sv
// -----------------------------------------------------------------------------
// synth_pkg
// Shared definitions for the synth engine and the note-event queue: event
// field widths, default FIFO geometry and small helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package synth_pkg;

    localparam int V_WIDTH_DEF = 3;   // voice address width
    localparam int E_WIDTH_DEF = 3;   // envelope index width
    localparam int DEPTH_DEF   = 4;   // note-event FIFO entries
    localparam int D_WIDTH_DEF = 2;   // log2(DEPTH_DEF)
    localparam int KEY_W       = 8;   // MIDI key number width
    localparam int VEL_W       = 8;   // velocity width

    typedef logic [KEY_W-1:0] key_t;
    typedef logic [VEL_W-1:0] vel_t;

    // Stored entry is {key_adr, key_val, vel}.
    function automatic int entry_width(input int v_width);
        return v_width + KEY_W + VEL_W;
    endfunction

    // 8-bit counter increment that sticks at 255.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/note_event_queue_if.sv
// -----------------------------------------------------------------------------
// note_event_queue_if
// Note-event handshake between the MIDI decoder side (master) and the
// note-event queue (slave).
//   note_on / cur_key_adr / cur_key_val / cur_vel_on : event strobe + payload
//   ev_valid / ev_key_adr / ev_key_val / ev_vel       : per-frame delivered event
// -----------------------------------------------------------------------------
interface note_event_queue_if
    import synth_pkg::*;
#(
    parameter int V_WIDTH = V_WIDTH_DEF
);
    logic               note_on;
    logic [V_WIDTH-1:0] cur_key_adr;
    key_t               cur_key_val;
    vel_t               cur_vel_on;

    logic               ev_valid;
    logic [V_WIDTH-1:0] ev_key_adr;
    key_t               ev_key_val;
    vel_t               ev_vel;

    modport master (
        output note_on, cur_key_adr, cur_key_val, cur_vel_on,
        input  ev_valid, ev_key_adr, ev_key_val, ev_vel
    );

    modport slave (
        input  note_on, cur_key_adr, cur_key_val, cur_vel_on,
        output ev_valid, ev_key_adr, ev_key_val, ev_vel
    );
endinterface

// File: rtl/note_event_fifo.sv
// -----------------------------------------------------------------------------
// note_event_fifo
// Small FIFO of note events with tail coalescing: a push whose voice address
// matches the tail entry overwrites that entry instead of allocating a new one.
// Ports:
//   OSC_CLK, iRST_N               : clock, async active-low reset
//   push, push_adr/key/vel        : write request and payload
//   pop                           : remove head entry (ignored when empty)
//   head_adr/key/vel              : current head entry (combinational)
//   fill                          : occupancy 0..DEPTH
//   drop                          : this cycle's push is being discarded
// -----------------------------------------------------------------------------
module note_event_fifo
    import synth_pkg::*;
#(
    parameter int V_WIDTH = V_WIDTH_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int D_WIDTH = D_WIDTH_DEF
) (
    input  logic               OSC_CLK,
    input  logic               iRST_N,
    input  logic               push,
    input  logic [V_WIDTH-1:0] push_adr,
    input  key_t               push_key,
    input  vel_t               push_vel,
    input  logic               pop,
    output logic [V_WIDTH-1:0] head_adr,
    output key_t               head_key,
    output vel_t               head_vel,
    output logic [D_WIDTH:0]   fill,
    output logic               drop
);
    localparam int EW = entry_width(V_WIDTH);

    logic [EW-1:0]      mem [DEPTH];
    logic [D_WIDTH-1:0] wr_ptr_reg, rd_ptr_reg, tail_ptr;
    logic [D_WIDTH:0]   fill_reg;
    logic [V_WIDTH-1:0] tail_adr;
    logic               pop_ok, pop_tail, coalesce, full, alloc;

    assign tail_ptr = wr_ptr_reg - D_WIDTH'(1);
    assign tail_adr = mem[tail_ptr][EW-1 -: V_WIDTH];

    assign pop_ok   = pop && (fill_reg != '0);
    // With a single entry, the tail is also the head leaving this cycle,
    // so merging into it would lose the new event.
    assign pop_tail = pop_ok && (fill_reg == (D_WIDTH+1)'(1));
    assign coalesce = push && (fill_reg != '0) && (tail_adr == push_adr) && !pop_tail;
    assign full     = (fill_reg == (D_WIDTH+1)'(DEPTH));
    // A pop in the same cycle frees the slot the push will take.
    assign drop     = push && !coalesce && full && !pop_ok;
    assign alloc    = push && !coalesce && !drop;

    // Storage carries no reset; its contents are meaningless while fill is 0.
    always_ff @(posedge OSC_CLK) begin
        if (coalesce) begin
            mem[tail_ptr] <= {push_adr, push_key, push_vel};
        end else if (alloc) begin
            mem[wr_ptr_reg] <= {push_adr, push_key, push_vel};
        end
    end

    always_ff @(posedge OSC_CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fill_reg   <= '0;
        end else begin
            if (alloc)  wr_ptr_reg <= wr_ptr_reg + D_WIDTH'(1);
            if (pop_ok) rd_ptr_reg <= rd_ptr_reg + D_WIDTH'(1);
            case ({alloc, pop_ok})
                2'b10:   fill_reg <= fill_reg + (D_WIDTH+1)'(1);
                2'b01:   fill_reg <= fill_reg - (D_WIDTH+1)'(1);
                default: fill_reg <= fill_reg;
            endcase
        end
    end

    assign {head_adr, head_key, head_vel} = mem[rd_ptr_reg];
    assign fill = fill_reg;

endmodule

// File: rtl/note_event_queue.sv
// -----------------------------------------------------------------------------
// note_event_queue
// Buffers note events from the MIDI decoder and releases at most one per
// synthesis frame, at the frame-start slot of the xxxx counter. Also latches
// a frame-coherent snapshot of keys_on and tracks dropped events.
// Ports:
//   OSC_CLK, iRST_N  : clock, async active-low reset
//   evq (slave)      : event push side and per-frame delivered event
//   keys_on          : live key-held vector
//   xxxx             : voice/envelope slot counter
//   ovf_clr          : clears overflow and drop_cnt (wins over a same-cycle drop)
//   frame_keys_on    : keys_on captured at frame start
//   fill             : FIFO occupancy
//   overflow         : sticky, set on a dropped event
//   drop_cnt         : dropped-event count, saturating at 255
// -----------------------------------------------------------------------------
module note_event_queue
    import synth_pkg::*;
#(
    parameter int VOICES  = 8,
    parameter int V_WIDTH = V_WIDTH_DEF,
    parameter int E_WIDTH = E_WIDTH_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int D_WIDTH = D_WIDTH_DEF
) (
    input  logic                       OSC_CLK,
    input  logic                       iRST_N,
    note_event_queue_if.slave          evq,
    input  logic [VOICES-1:0]          keys_on,
    input  logic [V_WIDTH+E_WIDTH-1:0] xxxx,
    input  logic                       ovf_clr,
    output logic [VOICES-1:0]          frame_keys_on,
    output logic [D_WIDTH:0]           fill,
    output logic                       overflow,
    output logic [7:0]                 drop_cnt
);
    logic [V_WIDTH+E_WIDTH-1:0] xxxx_q;
    logic                       frame_start, pop, drop;
    logic [V_WIDTH-1:0]         head_adr;
    key_t                       head_key;
    vel_t                       head_vel;

    logic                       ev_valid_reg;
    logic [V_WIDTH-1:0]         ev_key_adr_reg;
    key_t                       ev_key_val_reg;
    vel_t                       ev_vel_reg;
    logic [VOICES-1:0]          frame_keys_on_reg;
    logic                       overflow_reg;
    logic [7:0]                 drop_cnt_reg;

    // xxxx_q resets to 0, so a counter parked at 0 out of reset is not a frame start.
    assign frame_start = (xxxx == '0) && (xxxx_q != '0);
    assign pop         = frame_start && (fill != '0);

    note_event_fifo #(
        .V_WIDTH (V_WIDTH),
        .DEPTH   (DEPTH),
        .D_WIDTH (D_WIDTH)
    ) u_fifo (
        .OSC_CLK  (OSC_CLK),
        .iRST_N   (iRST_N),
        .push     (evq.note_on),
        .push_adr (evq.cur_key_adr),
        .push_key (evq.cur_key_val),
        .push_vel (evq.cur_vel_on),
        .pop      (pop),
        .head_adr (head_adr),
        .head_key (head_key),
        .head_vel (head_vel),
        .fill     (fill),
        .drop     (drop)
    );

    always_ff @(posedge OSC_CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            xxxx_q            <= '0;
            ev_valid_reg      <= 1'b0;
            ev_key_adr_reg    <= '0;
            ev_key_val_reg    <= '0;
            ev_vel_reg        <= '0;
            frame_keys_on_reg <= '0;
            overflow_reg      <= 1'b0;
            drop_cnt_reg      <= '0;
        end else begin
            xxxx_q <= xxxx;
            if (frame_start) begin
                // Empty frame: valid drops but the old payload is kept.
                ev_valid_reg      <= pop;
                frame_keys_on_reg <= keys_on;
                if (pop) begin
                    ev_key_adr_reg <= head_adr;
                    ev_key_val_reg <= head_key;
                    ev_vel_reg     <= head_vel;
                end
            end
            if (ovf_clr) begin
                overflow_reg <= 1'b0;
                drop_cnt_reg <= '0;
            end else if (drop) begin
                overflow_reg <= 1'b1;
                drop_cnt_reg <= sat_inc8(drop_cnt_reg);
            end
        end
    end

    assign evq.ev_valid   = ev_valid_reg;
    assign evq.ev_key_adr = ev_key_adr_reg;
    assign evq.ev_key_val = ev_key_val_reg;
    assign evq.ev_vel     = ev_vel_reg;
    assign frame_keys_on  = frame_keys_on_reg;
    assign overflow       = overflow_reg;
    assign drop_cnt       = drop_cnt_reg;

endmodule

// File: tb/tb_note_event_queue.sv
// -----------------------------------------------------------------------------
// tb_note_event_queue
// Directed bench for note_event_queue (VOICES=8, DEPTH=4). Inputs change 1 ns
// after a rising edge; outputs are read at the same point.
// -----------------------------------------------------------------------------
module tb_note_event_queue;

    logic       OSC_CLK = 1'b0;
    logic       iRST_N;
    logic [7:0] keys_on;
    logic [5:0] xxxx;
    logic       ovf_clr;
    logic [7:0] frame_keys_on;
    logic [2:0] fill;
    logic       overflow;
    logic [7:0] drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    note_event_queue_if #(.V_WIDTH(3)) evq ();

    note_event_queue #(
        .VOICES (8), .V_WIDTH (3), .E_WIDTH (3), .DEPTH (4), .D_WIDTH (2)
    ) dut (
        .OSC_CLK       (OSC_CLK),
        .iRST_N        (iRST_N),
        .evq           (evq),
        .keys_on       (keys_on),
        .xxxx          (xxxx),
        .ovf_clr       (ovf_clr),
        .frame_keys_on (frame_keys_on),
        .fill          (fill),
        .overflow      (overflow),
        .drop_cnt      (drop_cnt)
    );

    always #5 OSC_CLK = ~OSC_CLK;

    task automatic tick();
        @(posedge OSC_CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] adr, input logic [7:0] key, input logic [7:0] vel);
        evq.note_on     = 1'b1;
        evq.cur_key_adr = adr;
        evq.cur_key_val = key;
        evq.cur_vel_on  = vel;
        tick();
        evq.note_on     = 1'b0;
        $display("push adr=%0d key=%0d vel=%0d -> fill=%0d ovf=%0b drops=%0d",
                 adr, key, vel, fill, overflow, drop_cnt);
    endtask

    // One frame start: xxxx reads 0 for one cycle, then returns to a mid-frame slot.
    task automatic frame();
        xxxx = 6'd0;
        tick();
        xxxx = 6'd5;
        tick();
        $display("frame ev_valid=%0b adr=%0d key=%0d vel=%0d fill=%0d keys=%02h",
                 evq.ev_valid, evq.ev_key_adr, evq.ev_key_val, evq.ev_vel, fill, frame_keys_on);
    endtask

    task automatic check_ev(input string tag, input logic v, input logic [2:0] adr,
                            input logic [7:0] key, input logic [7:0] vel, input logic [2:0] f);
        check({tag, ".valid"}, evq.ev_valid, v);
        check({tag, ".adr"}, evq.ev_key_adr, adr);
        check({tag, ".key"}, evq.ev_key_val, key);
        check({tag, ".vel"}, evq.ev_vel, vel);
        check({tag, ".fill"}, fill, f);
    endtask

    task automatic check_all_zero(input string tag);
        check_ev(tag, 1'b0, 3'd0, 8'd0, 8'd0, 3'd0);
        check({tag, ".ovf"}, overflow, 1'b0);
        check({tag, ".drops"}, drop_cnt, 8'd0);
        check({tag, ".keys"}, frame_keys_on, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        iRST_N          = 1'b0;
        evq.note_on     = 1'b0;
        evq.cur_key_adr = '0;
        evq.cur_key_val = '0;
        evq.cur_vel_on  = '0;
        keys_on         = 8'hFF;
        xxxx            = 6'd5;
        ovf_clr         = 1'b0;
        repeat (2) tick();
        check_all_zero("reset");
        iRST_N  = 1'b1;
        keys_on = 8'h00;
        tick();

        // Single event
        push(3'd3, 8'd60, 8'd100);
        check("t1.fill_after_push", fill, 3'd1);
        check("t1.no_early_valid", evq.ev_valid, 1'b0);
        frame();
        check_ev("t1.deliver", 1'b1, 3'd3, 8'd60, 8'd100, 3'd0);
        frame();
        check_ev("t1.empty_hold", 1'b0, 3'd3, 8'd60, 8'd100, 3'd0);

        // Ordering
        push(3'd1, 8'd10, 8'd11);
        push(3'd2, 8'd20, 8'd21);
        push(3'd5, 8'd50, 8'd51);
        check("t2.fill3", fill, 3'd3);
        frame();
        check_ev("t2.ev0", 1'b1, 3'd1, 8'd10, 8'd11, 3'd2);
        frame();
        check_ev("t2.ev1", 1'b1, 3'd2, 8'd20, 8'd21, 3'd1);
        frame();
        check_ev("t2.ev2", 1'b1, 3'd5, 8'd50, 8'd51, 3'd0);

        // Coalesce
        push(3'd2, 8'd60, 8'd1);
        push(3'd2, 8'd64, 8'd2);
        check("t3.fill1", fill, 3'd1);
        frame();
        check_ev("t3.merged", 1'b1, 3'd2, 8'd64, 8'd2, 3'd0);
        frame();
        check("t3.single_event", evq.ev_valid, 1'b0);

        // No bypass: push on the frame-start cycle of an empty FIFO
        evq.note_on = 1'b1; evq.cur_key_adr = 3'd4; evq.cur_key_val = 8'd70; evq.cur_vel_on = 8'd7;
        xxxx = 6'd0;
        tick();
        evq.note_on = 1'b0;
        xxxx = 6'd5;
        tick();
        $display("push-on-frame adr=4 key=70 -> ev_valid=%0b fill=%0d", evq.ev_valid, fill);
        check("nb.valid0", evq.ev_valid, 1'b0);
        check("nb.fill1", fill, 3'd1);
        frame();
        check_ev("nb.next_frame", 1'b1, 3'd4, 8'd70, 8'd7, 3'd0);

        // Overflow
        for (int i = 0; i < 4; i++) push(3'(i), 8'(30 + i), 8'(90 + i));
        check("t4.fill_full", fill, 3'd4);
        check("t4.no_ovf_yet", overflow, 1'b0);
        for (int i = 4; i < 6; i++) push(3'(i), 8'(30 + i), 8'(90 + i));
        check("t4.fill_stays", fill, 3'd4);
        check("t4.ovf", overflow, 1'b1);
        check("t4.drops2", drop_cnt, 8'd2);
        // Clear wins over a same-cycle drop
        ovf_clr = 1'b1;
        push(3'd6, 8'd36, 8'd96);
        ovf_clr = 1'b0;
        check("t4.clr_ovf", overflow, 1'b0);
        check("t4.clr_drops", drop_cnt, 8'd0);
        for (int i = 0; i < 4; i++) begin
            frame();
            check_ev($sformatf("t4.drain%0d", i), 1'b1, 3'(i), 8'(30 + i), 8'(90 + i), 3'(3 - i));
        end
        frame();
        check("t4.drained", evq.ev_valid, 1'b0);

        // Full with simultaneous pop
        for (int i = 0; i < 4; i++) push(3'(i), 8'(40 + i), 8'd1);
        push(3'd7, 8'd47, 8'd1);
        check("t5.drop1", drop_cnt, 8'd1);
        evq.note_on = 1'b1; evq.cur_key_adr = 3'd6; evq.cur_key_val = 8'd46; evq.cur_vel_on = 8'd1;
        xxxx = 6'd0;
        tick();
        evq.note_on = 1'b0;
        xxxx = 6'd5;
        tick();
        $display("push-on-frame (full) adr=6 key=46 -> fill=%0d drops=%0d", fill, drop_cnt);
        check_ev("t5.pop", 1'b1, 3'd0, 8'd40, 8'd1, 3'd4);
        check("t5.drops_same", drop_cnt, 8'd1);
        frame(); check_ev("t5.d1", 1'b1, 3'd1, 8'd41, 8'd1, 3'd3);
        frame(); check_ev("t5.d2", 1'b1, 3'd2, 8'd42, 8'd1, 3'd2);
        frame(); check_ev("t5.d3", 1'b1, 3'd3, 8'd43, 8'd1, 3'd1);
        frame(); check_ev("t5.d6", 1'b1, 3'd6, 8'd46, 8'd1, 3'd0);

        // Drop counter saturation
        for (int i = 0; i < 4; i++) push(3'(i), 8'(i), 8'd2);
        for (int i = 0; i < 300; i++) push(3'(4 + (i % 2)), 8'd99, 8'd3);
        check("sat.drops255", drop_cnt, 8'd255);
        check("sat.ovf", overflow, 1'b1);
        check("sat.fill", fill, 3'd4);

        // Reset mid-operation, then snapshot
        keys_on = 8'h3C;
        frame();
        check_ev("t6.pre", 1'b1, 3'd0, 8'd0, 8'd2, 3'd3);
        check("t6.pre_keys", frame_keys_on, 8'h3C);
        #2;
        iRST_N = 1'b0;
        #1;
        check_all_zero("t6.async_reset");
        xxxx    = 6'd0;
        keys_on = 8'hA5;
        tick();
        tick();
        iRST_N = 1'b1;
        tick();
        tick();
        check("t6.no_false_frame", frame_keys_on, 8'h00);
        xxxx = 6'd5;
        tick();
        frame();
        check("t6.snapshot", frame_keys_on, 8'hA5);
        check("t6.valid0", evq.ev_valid, 1'b0);
        check("t6.fill0", fill, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/note_event_queue.md
# note_event_queue

Parametrised successor to the engine's single-register note-event capture. It buffers note events from the MIDI decoder in a small FIFO, on the `OSC_CLK` domain. It releases at most one event per synthesis frame, aligned to the frame-start slot of the `xxxx` voice/envelope counter. It also latches a frame-coherent `keys_on` snapshot. It sits between `midi_decoder` and `pitch_control` / `env_gen_indexed`. Unlike the single capture register, back-to-back notes within one frame are no longer lost, and overflow is observable.

## Interface
Parameters:
- `VOICES`, 8, number of voices.
- `V_WIDTH`, 3, voice address width (log2 `VOICES`).
- `E_WIDTH`, 3, envelope-index width; `xxxx` is `V_WIDTH+E_WIDTH` bits.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `D_WIDTH`, 2, log2 `DEPTH`.

Ports:
- `OSC_CLK` in 1: the single clock. Rising edge only.
- `iRST_N` in 1: reset, asynchronous and active-low.
- `note_on` in 1: one-cycle event strobe from the decoder.
- `cur_key_adr` in `V_WIDTH`: voice index of the event.
- `cur_key_val` in 8: MIDI key number.
- `cur_vel_on` in 8: note-on velocity.
- `keys_on` in `VOICES`: live key-held vector.
- `xxxx` in `V_WIDTH+E_WIDTH`: slot counter from `timing_gen`.
- `ovf_clr` in 1: clears `overflow` and `drop_cnt`.
- `ev_valid` out 1: the delivered event is valid for the current frame.
- `ev_key_adr` out `V_WIDTH`: delivered event voice index.
- `ev_key_val` out 8: delivered event key number.
- `ev_vel` out 8: delivered event velocity.
- `frame_keys_on` out `VOICES`: `keys_on` snapshot taken at frame start.
- `fill` out `D_WIDTH+1`: current FIFO occupancy.
- `overflow` out 1: sticky flag, set when an event is dropped.
- `drop_cnt` out 8: count of dropped events, saturating at 255.

## Operation
- **Frame start.** `frame_start = (xxxx == 0) && (xxxx_q != 0)`, where `xxxx_q` is `xxxx` registered one cycle.
  - `xxxx_q` resets to 0, so the first frame start is the first wrap to 0 after reset.
- **Push.** A push occurs when `note_on` is high. The entry written is {`cur_key_adr`, `cur_key_val`, `cur_vel_on`}.
- **Coalesce.** A push is merged into the tail entry instead of allocating a new one when all of the following hold:
  - `fill` ≥ 1;
  - the tail entry's `key_adr` equals `cur_key_adr`;
  - the tail is not the entry being popped this cycle.
  
  On a merge, `key_val` and `vel` are overwritten and `fill` is unchanged.
- **Pop.** On `frame_start`:
  - If `fill` > 0, the head entry is popped into the output registers and `ev_valid` is set to 1.
  - If `fill` = 0, `ev_valid` is set to 0 and the `ev_*` data registers hold their previous values.
  - In both cases, `ev_valid` and `ev_*` hold until the next `frame_start`.
- **Snapshot.** On every `frame_start`, `frame_keys_on` is loaded from `keys_on`, whether or not the FIFO is empty.
- **Full.** A non-coalescing push while `fill == DEPTH` with no pop in the same cycle is dropped. The drop sets `overflow` and increments `drop_cnt`, saturating at 255.
- **Full with simultaneous pop.** A push while full is accepted if a pop occurs in the same cycle; `fill` stays at `DEPTH`.
- **No bypass.** A push and a `frame_start` in the same cycle on an empty FIFO gives `ev_valid=0` for that frame. The event is delivered at the following `frame_start`.
- **Clear vs. drop.** `ovf_clr` has priority over a same-cycle drop: flag and count go to 0, and that drop is not counted.
- **Pointers.** Read and write pointers are `D_WIDTH` bits and wrap modulo `DEPTH`. `fill` is tracked separately.

## Timing
- **Reset.** All outputs are 0, including `fill=0`, `overflow=0`, `drop_cnt=0` and `frame_keys_on=0`. FIFO contents are don't-care.
- **Reset mid-frame.** Reset during operation discards queued events. Outputs return to 0 asynchronously.
- **Frame-start latency.** Outputs update on the clock edge after the cycle in which `xxxx` first reads 0 (one cycle of frame-start detection).
- **Push latency.** `fill` updates on the edge after a push or pop.
- **Drop flags.** `overflow` and `drop_cnt` update on the edge after the dropped `note_on`.
- **Throughput.** Pushes are accepted every cycle. Pops are limited to one per frame (`2^(V_WIDTH+E_WIDTH)` slots).

## Structure
- **Shared package `synth_pkg`.** Holds the event field widths, the entry width (`V_WIDTH+16`) and the `DEPTH`/`D_WIDTH` defaults, shared with `synth_engine`.
- **Sub-module `note_event_fifo`.** Contains the storage array, the pointers, `fill`, and the coalesce compare.
- **Top.** Holds frame-start detection, the output registers, the snapshot, and the overflow logic.

## Test plan
1. **Single event.** After reset, pulse `note_on` (adr 3, key 60, vel 100) mid-frame → at the next frame start `ev_valid=1`, `ev_key_adr=3`, `ev_key_val=60`, `ev_vel=100`. At the following frame start `ev_valid=0` and `fill=0`.
2. **Ordering.** Push 3 events with distinct adr 1, 2, 5 in one frame → delivered in order over 3 consecutive frames, with `fill` reading 3, 2, 1, 0.
3. **Coalesce.** Push adr 2 key 60, then adr 2 key 64 → `fill=1`, and a single delivered event with key 64.
4. **Overflow.** Push 6 distinct-adr events with `DEPTH=4` and no frame start → `fill=4`, `overflow=1`, `drop_cnt=2`, and the first 4 events are delivered. Then pulse `ovf_clr` → `overflow=0`, `drop_cnt=0`.
5. **Full with pop.** With the FIFO full, push on the `frame_start` cycle → the push is accepted, `fill` stays 4, and `drop_cnt` is unchanged.
6. **Reset and snapshot.** Assert `iRST_N=0` with 3 events queued → all outputs are 0 immediately. After release, drive `keys_on=8'hA5` → `frame_keys_on=8'hA5` after the first frame start, with `ev_valid=0`.
